ctrl_sequencer: RTL and testbench
=================================

Name: ctrl_sequencer

Overview:
Hardwired control unit that sequences the datapath through instruction fetch (T0–T2) and execute (T3–T6) for register-register ALU, unary, and MUL/DIV instructions. It drives every strobe the datapath exposes (PCout, incPC, MARin, Read, MDRin, MDRout, IRin, Yin, Zin, ZLowOut, ZHighOut, HIin, LOin, PCin, opcode, per-register in/out enables), so the datapath no longer needs hand-driven stimulus. It decodes the IR value returned by the datapath.

Parameters:
NREG, 16, number of general registers; width of the rin/rout one-hot vectors.
OPW, 5, opcode width, taken from IR[31:27].

Ports:
clk  in  1  system clock; all state changes on rising edge
clr  in  1  asynchronous, active-low reset
run  in  1  level; permits leaving IDLE and starting the next fetch
mem_rdy  in  1  memory read data valid; T1 holds until it is high
ir  in  32  IR contents from the datapath
pc_out, inc_pc, mar_in, z_in, zlow_out, zhigh_out, pc_in, read, mdr_in, mdr_out, ir_in, y_in, hi_in, lo_in  out  1 each  datapath strobes
rin  out  NREG  one-hot register load enable (R0in..R15in)
rout  out  NREG  one-hot register drive enable (R0out..R15out)
alu_op  out  OPW  ALU opcode; 0 whenever no Zin is asserted
busy  out  1  high in every state except IDLE and HALT
halted  out  1  high in HALT
illegal  out  1  sticky; set on undefined opcode, cleared only by reset

Behaviour:
- clr low (any time, including mid-instruction): state goes to IDLE, all outputs go to 0, and illegal clears. Outputs stay 0 until the first rising edge after clr is released.
- Outputs are a Moore decode of the current state plus the IR fields latched at the end of T2. Each state lasts exactly one clock except T1.
- IR fields: op=ir[31:27], ra=ir[26:23], rb=ir[22:19], rc=ir[18:15]. They are captured into internal registers when leaving T2; ir is ignored at all other times.
- IDLE: no strobes. Go to T0 when run=1.
- T0: pc_out, mar_in, inc_pc, z_in.
- T1: zlow_out, pc_in, read, mdr_in. Stay in T1 while mem_rdy=0; pc_in is asserted only in the cycle where mem_rdy=1 (PC updates once).
- T2: mdr_out, ir_in. Go to T3, or back to T0/IDLE for NOP, or to HALT.
- 3-operand ALU (ADD, SUB, AND, OR, SHR, SHL, ROR, ROL):
  - T3: rout[rb], y_in.
  - T4: rout[rc], alu_op=op, z_in.
  - T5: zlow_out, rin[ra].
- Unary (NEG, NOT):
  - T3: rout[rb], alu_op=op, z_in.
  - T4: zlow_out, rin[ra].
- MUL/DIV:
  - T3: rout[ra], y_in.
  - T4: rout[rb], alu_op=op, z_in.
  - T5: zlow_out, lo_in.
  - T6: zhigh_out, hi_in.
- NOP: ends after T2.
- HALT: enter HALT and remain there until reset, ignoring run.
- Undefined opcode: set illegal and treat as NOP.
- End of instruction: if run=1 go to T0 (back-to-back, no gap cycle); otherwise go to IDLE. Dropping run mid-instruction never truncates the instruction.
- At most one bit of rout is set in any cycle. At most one of the bus drivers (pc_out, zlow_out, zhigh_out, mdr_out, any rout bit) is asserted in any cycle. rin and rout never share a cycle.
- Instruction latency with mem_rdy tied high: ALU 6, unary 5, MUL/DIV 7, NOP 3 clocks.

Decomposition:
- Package ctrl_pkg holds:
  - state encoding: IDLE, T0..T6, HALT;
  - opcode constants: ADD=00011, SUB=00100, SHR=00101, SHL=00110, ROR=00111, ROL=01000, AND=01001, OR=01010, MUL=01111, DIV=10000, NEG=10001, NOT=10010, NOP=11010, HALT=11011;
  - IR field bit positions;
  - op-class decode function.
- One sub-module, reg_onehot_dec: 4-bit index plus enable in, NREG-bit one-hot out. Instantiate it twice, once for rin and once for rout.

Test Plan:
- Reset mid-T4 of ADD: pull clr low asynchronously between edges -> all outputs 0 immediately; after release, IDLE; busy=0; illegal=0.
- run=1, mem_rdy=1, ir=0x18228000 (ADD R0,R4,R5) -> T3 rout=0x0010 + y_in; T4 rout=0x0020, alu_op=00011, z_in; T5 zlow_out, rin=0x0001. 6 clocks total.
- ir=0x7A280000 (MUL R4,R5) -> T3 rout=0x0010; T4 rout=0x0020, alu_op=01111; T5 lo_in; T6 hi_in. Next fetch T0 at clock 8.
- mem_rdy held low 3 cycles in T1 -> T1 lasts 4 cycles; pc_in high only in the final T1 cycle; read high all 4 cycles.
- HALT opcode 11011 -> halted=1 and busy=0 after T2, persisting with run=1. Undefined opcode 11111 -> illegal=1, next T0 follows T2.
- Checker across all scenarios -> bus-driver one-hot and rin/rout exclusivity assertions never fire; alu_op=0 whenever z_in=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the hardwired control sequencer.
package ctrl_pkg;

  // Sequencer states: fetch T0..T2, execute T3..T6.
  typedef enum logic [3:0] {
    StIdle,
    StT0,
    StT1,
    StT2,
    StT3,
    StT4,
    StT5,
    StT6,
    StHalt
  } state_e;

  // Instruction classes that select the execute sequence.
  typedef enum logic [2:0] {
    ClsAlu3,
    ClsUnary,
    ClsMulDiv,
    ClsNop,
    ClsHalt,
    ClsIllegal
  } op_class_e;

  // Single-bit datapath strobes, registered together.
  typedef struct packed {
    logic pc_out;
    logic inc_pc;
    logic mar_in;
    logic z_in;
    logic zlow_out;
    logic zhigh_out;
    logic pc_in_en;
    logic read;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic y_in;
    logic hi_in;
    logic lo_in;
  } strobe_t;

  localparam logic [4:0] OpAdd  = 5'b00011;
  localparam logic [4:0] OpSub  = 5'b00100;
  localparam logic [4:0] OpShr  = 5'b00101;
  localparam logic [4:0] OpShl  = 5'b00110;
  localparam logic [4:0] OpRor  = 5'b00111;
  localparam logic [4:0] OpRol  = 5'b01000;
  localparam logic [4:0] OpAnd  = 5'b01001;
  localparam logic [4:0] OpOr   = 5'b01010;
  localparam logic [4:0] OpMul  = 5'b01111;
  localparam logic [4:0] OpDiv  = 5'b10000;
  localparam logic [4:0] OpNeg  = 5'b10001;
  localparam logic [4:0] OpNot  = 5'b10010;
  localparam logic [4:0] OpNop  = 5'b11010;
  localparam logic [4:0] OpHalt = 5'b11011;

  // IR field positions.
  localparam int unsigned IrOpMsb = 31;
  localparam int unsigned IrOpLsb = 27;
  localparam int unsigned IrRaMsb = 26;
  localparam int unsigned IrRaLsb = 23;
  localparam int unsigned IrRbMsb = 22;
  localparam int unsigned IrRbLsb = 19;
  localparam int unsigned IrRcMsb = 18;
  localparam int unsigned IrRcLsb = 15;

  function automatic op_class_e op_class(input logic [4:0] op);
    op_class_e cls;
    case (op)
      OpAdd, OpSub, OpShr, OpShl, OpRor, OpRol, OpAnd, OpOr: cls = ClsAlu3;
      OpNeg, OpNot:                                          cls = ClsUnary;
      OpMul, OpDiv:                                          cls = ClsMulDiv;
      OpNop:                                                 cls = ClsNop;
      OpHalt:                                                cls = ClsHalt;
      default:                                               cls = ClsIllegal;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/ctrl_sequencer_dec.sv
// 4-bit register index to one-hot enable vector; all zero when disabled.
module reg_onehot_dec #(
  parameter int unsigned NREG = 16
) (
  input  logic [3:0]      idx_i,
  input  logic            en_i,
  output logic [NREG-1:0] onehot_o
);

  // Index beyond NREG yields no enable rather than wrapping.
  always_comb begin
    onehot_o = '0;
    if (en_i && (32'(idx_i) < NREG)) begin
      onehot_o[idx_i] = 1'b1;
    end
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Hardwired fetch/execute sequencer driving all datapath strobes.
// Outputs are registered from the next state so they are glitch-free and
// clear immediately on clr; pc_in alone is qualified by mem_rdy so the PC
// loads exactly once however long T1 is stretched.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int unsigned NREG = 16,
  parameter int unsigned OPW  = 5
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            run,
  input  logic            mem_rdy,
  input  logic [31:0]     ir,
  output logic            pc_out,
  output logic            inc_pc,
  output logic            mar_in,
  output logic            z_in,
  output logic            zlow_out,
  output logic            zhigh_out,
  output logic            pc_in,
  output logic            read,
  output logic            mdr_in,
  output logic            mdr_out,
  output logic            ir_in,
  output logic            y_in,
  output logic            hi_in,
  output logic            lo_in,
  output logic [NREG-1:0] rin,
  output logic [NREG-1:0] rout,
  output logic [OPW-1:0]  alu_op,
  output logic            busy,
  output logic            halted,
  output logic            illegal
);

  state_e          state_q, state_d, end_state;
  logic [4:0]      op_q, op_d;
  logic [3:0]      ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
  logic            illegal_q, illegal_d;
  op_class_e       cls_q, cls_d, ir_cls;

  strobe_t         strb_q, strb_d;
  logic [NREG-1:0] rin_q, rin_d, rout_q, rout_d;
  logic [3:0]      rin_idx_d, rout_idx_d;
  logic            rin_en_d, rout_en_d;
  logic [OPW-1:0]  alu_op_q, alu_op_d;
  logic            busy_q, busy_d, halted_q, halted_d;

  logic            unused_ir;
  assign unused_ir = ^ir[IrRcLsb-1:0];

  // Next-state logic; IR fields are captured only when leaving T2.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    rc_d      = rc_q;
    illegal_d = illegal_q;
    cls_q     = op_class(op_q);
    ir_cls    = op_class(ir[IrOpMsb:IrOpLsb]);
    end_state = run ? StT0 : StIdle;
    unique case (state_q)
      StIdle: if (run) state_d = StT0;
      StT0:   state_d = StT1;
      StT1:   if (mem_rdy) state_d = StT2;
      StT2: begin
        op_d = ir[IrOpMsb:IrOpLsb];
        ra_d = ir[IrRaMsb:IrRaLsb];
        rb_d = ir[IrRbMsb:IrRbLsb];
        rc_d = ir[IrRcMsb:IrRcLsb];
        case (ir_cls)
          ClsAlu3, ClsUnary, ClsMulDiv: state_d = StT3;
          ClsHalt:                      state_d = StHalt;
          ClsIllegal: begin
            illegal_d = 1'b1;
            state_d   = end_state;
          end
          default:                      state_d = end_state;
        endcase
      end
      StT3:   state_d = StT4;
      StT4:   state_d = (cls_q == ClsUnary) ? end_state : StT5;
      StT5:   state_d = (cls_q == ClsMulDiv) ? StT6 : end_state;
      StT6:   state_d = end_state;
      StHalt: state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  // Output decode of the upcoming state, registered below.
  always_comb begin
    strb_d     = '0;
    rin_idx_d  = '0;
    rin_en_d   = 1'b0;
    rout_idx_d = '0;
    rout_en_d  = 1'b0;
    alu_op_d   = '0;
    cls_d      = op_class(op_d);
    busy_d     = !(state_d inside {StIdle, StHalt});
    halted_d   = (state_d == StHalt);
    unique case (state_d)
      StT0: begin
        strb_d.pc_out = 1'b1;
        strb_d.mar_in = 1'b1;
        strb_d.inc_pc = 1'b1;
        strb_d.z_in   = 1'b1;
      end
      StT1: begin
        strb_d.zlow_out = 1'b1;
        strb_d.pc_in_en = 1'b1;
        strb_d.read     = 1'b1;
        strb_d.mdr_in   = 1'b1;
      end
      StT2: begin
        strb_d.mdr_out = 1'b1;
        strb_d.ir_in   = 1'b1;
      end
      StT3: begin
        rout_en_d = 1'b1;
        if (cls_d == ClsMulDiv) begin
          rout_idx_d  = ra_d;
          strb_d.y_in = 1'b1;
        end else if (cls_d == ClsUnary) begin
          rout_idx_d  = rb_d;
          alu_op_d    = OPW'(op_d);
          strb_d.z_in = 1'b1;
        end else begin
          rout_idx_d  = rb_d;
          strb_d.y_in = 1'b1;
        end
      end
      StT4: begin
        if (cls_d == ClsUnary) begin
          strb_d.zlow_out = 1'b1;
          rin_en_d        = 1'b1;
          rin_idx_d       = ra_d;
        end else begin
          rout_en_d   = 1'b1;
          rout_idx_d  = (cls_d == ClsMulDiv) ? rb_d : rc_d;
          alu_op_d    = OPW'(op_d);
          strb_d.z_in = 1'b1;
        end
      end
      StT5: begin
        strb_d.zlow_out = 1'b1;
        if (cls_d == ClsMulDiv) begin
          strb_d.lo_in = 1'b1;
        end else begin
          rin_en_d  = 1'b1;
          rin_idx_d = ra_d;
        end
      end
      StT6: begin
        strb_d.zhigh_out = 1'b1;
        strb_d.hi_in     = 1'b1;
      end
      default: ;
    endcase
  end

  reg_onehot_dec #(
    .NREG(NREG)
  ) u_rin_dec (
    .idx_i    (rin_idx_d),
    .en_i     (rin_en_d),
    .onehot_o (rin_d)
  );

  reg_onehot_dec #(
    .NREG(NREG)
  ) u_rout_dec (
    .idx_i    (rout_idx_d),
    .en_i     (rout_en_d),
    .onehot_o (rout_d)
  );

  // State, latched IR fields and registered outputs.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= StIdle;
      op_q      <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      rc_q      <= '0;
      illegal_q <= 1'b0;
      strb_q    <= '0;
      rin_q     <= '0;
      rout_q    <= '0;
      alu_op_q  <= '0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      rc_q      <= rc_d;
      illegal_q <= illegal_d;
      strb_q    <= strb_d;
      rin_q     <= rin_d;
      rout_q    <= rout_d;
      alu_op_q  <= alu_op_d;
      busy_q    <= busy_d;
      halted_q  <= halted_d;
    end
  end

  assign pc_out    = strb_q.pc_out;
  assign inc_pc    = strb_q.inc_pc;
  assign mar_in    = strb_q.mar_in;
  assign z_in      = strb_q.z_in;
  assign zlow_out  = strb_q.zlow_out;
  assign zhigh_out = strb_q.zhigh_out;
  assign pc_in     = strb_q.pc_in_en & mem_rdy;
  assign read      = strb_q.read;
  assign mdr_in    = strb_q.mdr_in;
  assign mdr_out   = strb_q.mdr_out;
  assign ir_in     = strb_q.ir_in;
  assign y_in      = strb_q.y_in;
  assign hi_in     = strb_q.hi_in;
  assign lo_in     = strb_q.lo_in;
  assign rin       = rin_q;
  assign rout      = rout_q;
  assign alu_op    = alu_op_q;
  assign busy      = busy_q;
  assign halted    = halted_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: per-cycle strobe vectors per scenario.
module tb_ctrl_sequencer;

  logic        clk, clr, run, mem_rdy;
  logic [31:0] ir;
  logic        pc_out, inc_pc, mar_in, z_in, zlow_out, zhigh_out, pc_in, read;
  logic        mdr_in, mdr_out, ir_in, y_in, hi_in, lo_in, busy, halted, illegal;
  logic [15:0] rin, rout;
  logic [4:0]  alu_op;

  int n_cmp  = 0;
  int n_fail = 0;
  logic ill_exp = 1'b0;

  // Strobe masks in snapshot order.
  localparam logic [13:0] PCOUT  = 14'h2000;
  localparam logic [13:0] INCPC  = 14'h1000;
  localparam logic [13:0] MARIN  = 14'h0800;
  localparam logic [13:0] ZIN    = 14'h0400;
  localparam logic [13:0] ZLOW   = 14'h0200;
  localparam logic [13:0] ZHIGH  = 14'h0100;
  localparam logic [13:0] PCIN   = 14'h0080;
  localparam logic [13:0] READ   = 14'h0040;
  localparam logic [13:0] MDRIN  = 14'h0020;
  localparam logic [13:0] MDROUT = 14'h0010;
  localparam logic [13:0] IRIN   = 14'h0008;
  localparam logic [13:0] YIN    = 14'h0004;
  localparam logic [13:0] HIIN   = 14'h0002;
  localparam logic [13:0] LOIN   = 14'h0001;
  localparam logic [13:0] F0     = PCOUT | MARIN | INCPC | ZIN;
  localparam logic [13:0] F1     = ZLOW | PCIN | READ | MDRIN;
  localparam logic [13:0] F1W    = ZLOW | READ | MDRIN;
  localparam logic [13:0] F2     = MDROUT | IRIN;
  localparam logic [31:0] IrAdd  = 32'h1822_8000;
  localparam logic [31:0] IrMul  = 32'h7A28_0000;

  ctrl_sequencer #(
    .NREG(16),
    .OPW (5)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .run       (run),
    .mem_rdy   (mem_rdy),
    .ir        (ir),
    .pc_out    (pc_out),
    .inc_pc    (inc_pc),
    .mar_in    (mar_in),
    .z_in      (z_in),
    .zlow_out  (zlow_out),
    .zhigh_out (zhigh_out),
    .pc_in     (pc_in),
    .read      (read),
    .mdr_in    (mdr_in),
    .mdr_out   (mdr_out),
    .ir_in     (ir_in),
    .y_in      (y_in),
    .hi_in     (hi_in),
    .lo_in     (lo_in),
    .rin       (rin),
    .rout      (rout),
    .alu_op    (alu_op),
    .busy      (busy),
    .halted    (halted),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [53:0] snap();
    return {pc_out, inc_pc, mar_in, z_in, zlow_out, zhigh_out, pc_in, read, mdr_in, mdr_out,
            ir_in, y_in, hi_in, lo_in, rin, rout, alu_op, busy, halted, illegal};
  endfunction

  function automatic logic [53:0] ev(input logic [13:0] s, input logic [15:0] ri,
                                     input logic [15:0] ro, input logic [4:0] a,
                                     input logic b, input logic h, input logic il);
    return {s, ri, ro, a, b, h, il};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run with run=0 until the sequencer is idle again, bounded.
  task automatic drain();
    run = 1'b0;
    for (int i = 0; i < 20 && busy === 1'b1; i++) tick();
  endtask

  // Structural invariants, sampled every falling edge.
  always @(negedge clk) begin
    n_cmp++;
    if ($countones({pc_out, zlow_out, zhigh_out, mdr_out, rout}) > 1) begin
      n_fail++;
      $display("FAIL bus_onehot: got drivers pc=%b zl=%b zh=%b mdr=%b rout=%h want at most one",
               pc_out, zlow_out, zhigh_out, mdr_out, rout);
    end
    n_cmp++;
    if (rin != 0 && rout != 0) begin
      n_fail++;
      $display("FAIL rin_rout_excl: got rin=%h rout=%h want not both", rin, rout);
    end
    n_cmp++;
    if (!z_in && alu_op != 0) begin
      n_fail++;
      $display("FAIL aluop_zero: got alu_op=%b with z_in=0 want 0", alu_op);
    end
  end

  task automatic test_reset();
    logic [53:0] got;
    clr = 1'b0; run = 1'b0; mem_rdy = 1'b1; ir = '0;
    repeat (2) @(posedge clk);
    #1;
    got = snap(); n_cmp++;
    if (got !== ev(0, 0, 0, 0, 0, 0, 0)) begin
      n_fail++; $display("FAIL reset_hold: got %h want %h", got, ev(0, 0, 0, 0, 0, 0, 0));
    end
    @(negedge clk) clr = 1'b1;
    tick();
    got = snap(); n_cmp++;
    if (got !== ev(0, 0, 0, 0, 0, 0, 0)) begin
      n_fail++; $display("FAIL reset_idle: got %h want %h", got, ev(0, 0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_alu_add();
    logic [53:0] ex [7];
    logic [53:0] got;
    ex[0] = ev(F0, 0, 0, 0, 1, 0, 0);
    ex[1] = ev(F1, 0, 0, 0, 1, 0, 0);
    ex[2] = ev(F2, 0, 0, 0, 1, 0, 0);
    ex[3] = ev(YIN, 0, 16'h0010, 0, 1, 0, 0);
    ex[4] = ev(ZIN, 0, 16'h0020, 5'b00011, 1, 0, 0);
    ex[5] = ev(ZLOW, 16'h0001, 0, 0, 1, 0, 0);
    ex[6] = ev(F0, 0, 0, 0, 1, 0, 0);
    ir = IrAdd; mem_rdy = 1'b1; run = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      got = snap(); n_cmp++;
      if (got !== ex[i]) begin
        n_fail++; $display("FAIL add_c%0d: got %h want %h", i + 1, got, ex[i]);
      end
    end
    drain();
    got = snap(); n_cmp++;
    if (got !== ev(0, 0, 0, 0, 0, 0, 0)) begin
      n_fail++; $display("FAIL add_end_idle: got %h want %h", got, ev(0, 0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_mul();
    logic [53:0] ex [8];
    logic [53:0] got;
    ex[0] = ev(F0, 0, 0, 0, 1, 0, 0);
    ex[1] = ev(F1, 0, 0, 0, 1, 0, 0);
    ex[2] = ev(F2, 0, 0, 0, 1, 0, 0);
    ex[3] = ev(YIN, 0, 16'h0010, 0, 1, 0, 0);
    ex[4] = ev(ZIN, 0, 16'h0020, 5'b01111, 1, 0, 0);
    ex[5] = ev(ZLOW | LOIN, 0, 0, 0, 1, 0, 0);
    ex[6] = ev(ZHIGH | HIIN, 0, 0, 0, 1, 0, 0);
    ex[7] = ev(F0, 0, 0, 0, 1, 0, 0);
    ir = IrMul; mem_rdy = 1'b1; run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      got = snap(); n_cmp++;
      if (got !== ex[i]) begin
        n_fail++; $display("FAIL mul_c%0d: got %h want %h", i + 1, got, ex[i]);
      end
    end
    drain();
    got = snap(); n_cmp++;
    if (got !== ev(0, 0, 0, 0, 0, 0, 0)) begin
      n_fail++; $display("FAIL mul_end_idle: got %h want %h", got, ev(0, 0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_mem_wait();
    logic [53:0] got;
    ir = IrAdd; mem_rdy = 1'b0; run = 1'b1;
    tick();
    got = snap(); n_cmp++;
    if (got !== ev(F0, 0, 0, 0, 1, 0, 0)) begin
      n_fail++; $display("FAIL wait_t0: got %h want %h", got, ev(F0, 0, 0, 0, 1, 0, 0));
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      got = snap(); n_cmp++;
      if (got !== ev(F1W, 0, 0, 0, 1, 0, 0)) begin
        n_fail++; $display("FAIL wait_t1_c%0d: got %h want %h", i + 1, got,
                           ev(F1W, 0, 0, 0, 1, 0, 0));
      end
    end
    mem_rdy = 1'b1;
    #1;
    got = snap(); n_cmp++;
    if (got !== ev(F1, 0, 0, 0, 1, 0, 0)) begin
      n_fail++; $display("FAIL wait_t1_rdy: got %h want %h", got, ev(F1, 0, 0, 0, 1, 0, 0));
    end
    tick();
    got = snap(); n_cmp++;
    if (got !== ev(F2, 0, 0, 0, 1, 0, 0)) begin
      n_fail++; $display("FAIL wait_t2: got %h want %h", got, ev(F2, 0, 0, 0, 1, 0, 0));
    end
    drain();
  endtask

  task automatic test_unary();
    logic [53:0] ex [6];
    logic [53:0] got;
    ex[0] = ev(F0, 0, 0, 0, 1, 0, 0);
    ex[1] = ev(F1, 0, 0, 0, 1, 0, 0);
    ex[2] = ev(F2, 0, 0, 0, 1, 0, 0);
    ex[3] = ev(ZIN, 0, 16'h0080, 5'b10001, 1, 0, 0);
    ex[4] = ev(ZLOW, 16'h0008, 0, 0, 1, 0, 0);
    ex[5] = ev(F0, 0, 0, 0, 1, 0, 0);
    ir = {5'b10001, 4'd3, 4'd7, 19'd0}; mem_rdy = 1'b1; run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      got = snap(); n_cmp++;
      if (got !== ex[i]) begin
        n_fail++; $display("FAIL neg_c%0d: got %h want %h", i + 1, got, ex[i]);
      end
    end
    drain();
  endtask

  task automatic test_nop_back_to_back();
    logic [53:0] ex [4];
    logic [53:0] got;
    ex[0] = ev(F0, 0, 0, 0, 1, 0, 0);
    ex[1] = ev(F1, 0, 0, 0, 1, 0, 0);
    ex[2] = ev(F2, 0, 0, 0, 1, 0, 0);
    ex[3] = ev(F0, 0, 0, 0, 1, 0, 0);
    ir = {5'b11010, 27'd0}; mem_rdy = 1'b1; run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      got = snap(); n_cmp++;
      if (got !== ex[i]) begin
        n_fail++; $display("FAIL nop_c%0d: got %h want %h", i + 1, got, ex[i]);
      end
    end
    drain();
    got = snap(); n_cmp++;
    if (got !== ev(0, 0, 0, 0, 0, 0, 0)) begin
      n_fail++; $display("FAIL nop_end_idle: got %h want %h", got, ev(0, 0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_illegal();
    logic [53:0] ex [4];
    logic [53:0] got;
    ex[0] = ev(F0, 0, 0, 0, 1, 0, 0);
    ex[1] = ev(F1, 0, 0, 0, 1, 0, 0);
    ex[2] = ev(F2, 0, 0, 0, 1, 0, 0);
    ex[3] = ev(F0, 0, 0, 0, 1, 0, 1);
    ir = {5'b11111, 27'd0}; mem_rdy = 1'b1; run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      got = snap(); n_cmp++;
      if (got !== ex[i]) begin
        n_fail++; $display("FAIL illegal_c%0d: got %h want %h", i + 1, got, ex[i]);
      end
    end
    ill_exp = 1'b1;
    drain();
    got = snap(); n_cmp++;
    if (got !== ev(0, 0, 0, 0, 0, 0, ill_exp)) begin
      n_fail++; $display("FAIL illegal_sticky: got %h want %h", got,
                         ev(0, 0, 0, 0, 0, 0, ill_exp));
    end
  endtask

  task automatic test_reset_mid_t4();
    logic [53:0] got;
    ir = IrAdd; mem_rdy = 1'b1; run = 1'b1;
    repeat (5) tick();
    got = snap(); n_cmp++;
    if (got !== ev(ZIN, 0, 16'h0020, 5'b00011, 1, 0, ill_exp)) begin
      n_fail++; $display("FAIL rst_pre_t4: got %h want %h", got,
                         ev(ZIN, 0, 16'h0020, 5'b00011, 1, 0, ill_exp));
    end
    #2 clr = 1'b0;
    ill_exp = 1'b0;
    #1;
    got = snap(); n_cmp++;
    if (got !== ev(0, 0, 0, 0, 0, 0, 0)) begin
      n_fail++; $display("FAIL rst_async: got %h want %h", got, ev(0, 0, 0, 0, 0, 0, 0));
    end
    run = 1'b0;
    @(negedge clk) clr = 1'b1;
    tick();
    got = snap(); n_cmp++;
    if (got !== ev(0, 0, 0, 0, 0, 0, 0)) begin
      n_fail++; $display("FAIL rst_release_idle: got %h want %h", got, ev(0, 0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_halt();
    logic [53:0] ex [3];
    logic [53:0] got;
    ex[0] = ev(F0, 0, 0, 0, 1, 0, 0);
    ex[1] = ev(F1, 0, 0, 0, 1, 0, 0);
    ex[2] = ev(F2, 0, 0, 0, 1, 0, 0);
    ir = {5'b11011, 27'd0}; mem_rdy = 1'b1; run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      got = snap(); n_cmp++;
      if (got !== ex[i]) begin
        n_fail++; $display("FAIL halt_c%0d: got %h want %h", i + 1, got, ex[i]);
      end
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      got = snap(); n_cmp++;
      if (got !== ev(0, 0, 0, 0, 0, 1, 0)) begin
        n_fail++; $display("FAIL halt_hold_c%0d: got %h want %h", i + 1, got,
                           ev(0, 0, 0, 0, 0, 1, 0));
      end
    end
    clr = 1'b0;
    #1;
    got = snap(); n_cmp++;
    if (got !== ev(0, 0, 0, 0, 0, 0, 0)) begin
      n_fail++; $display("FAIL halt_reset: got %h want %h", got, ev(0, 0, 0, 0, 0, 0, 0));
    end
  endtask

  initial begin
    test_reset();
    test_alu_add();
    test_mul();
    test_mem_wait();
    test_unary();
    test_nop_back_to_back();
    test_illegal();
    test_reset_mid_t4();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
